// File: rtl/cmd_receiver_pkg.sv
// Shared constants and types for the SLIP command receiver.
// SLIP framing bytes, the command width and the receiver FSM states.
package cmd_receiver_pkg;

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

  localparam int CMD_W = 40;

  typedef enum logic [1:0] {
    ST_RECEIVE = 2'd0,
    ST_ESCAPE  = 2'd1,
    ST_DISCARD = 2'd2
  } rx_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead synchronous command FIFO with a parameterised depth.
// A push is refused on pre-pop fullness, so a same-cycle pop never makes room.
module cmd_fifo
  import cmd_receiver_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [CMD_W-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [CMD_W-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [OW-1:0]    r_occ;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_occ == OW'(DEPTH));
  assign o_empty = (r_occ == '0);
  assign w_wr    = i_wr_en & ~o_full;
  assign w_rd    = i_rd_en & ~o_empty;

  assign o_rd_data = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_wr && !w_rd) begin
        r_occ <= r_occ + OW'(1);
      end else if (w_rd && !w_wr) begin
        r_occ <= r_occ - OW'(1);
      end
    end
  end

endmodule

// File: rtl/cmd_receiver.sv
// SLIP frame decoder turning host bytes into 40-bit monitor commands.
// Bad frames and overflows are dropped and flagged with one-cycle strobes.
module cmd_receiver
  import cmd_receiver_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_ready,
  input  logic             cmd_read_en,
  output logic             frame_err,
  output logic             overflow
);

  rx_state_e        r_state;
  rx_state_e        w_state_nx;
  logic [2:0]       r_count;
  logic [2:0]       w_count_nx;
  logic [7:0]       r_bytes [5];
  logic             w_store;
  logic [7:0]       w_store_byte;
  logic             w_push;
  logic             w_err;
  logic             w_full;
  logic             w_empty;
  logic [CMD_W-1:0] w_push_cmd;
  logic             w_is_end;
  logic             w_is_esc;
  logic             w_is_esc_end;
  logic             w_is_esc_esc;
  logic             r_frame_err;
  logic             r_overflow;

  assign w_is_end     = (rx_byte == SLIP_END);
  assign w_is_esc     = (rx_byte == SLIP_ESC);
  assign w_is_esc_end = (rx_byte == SLIP_ESC_END);
  assign w_is_esc_esc = (rx_byte == SLIP_ESC_ESC);

  always_comb begin
    w_state_nx   = r_state;
    w_count_nx   = r_count;
    w_store      = 1'b0;
    w_store_byte = rx_byte;
    w_push       = 1'b0;
    w_err        = 1'b0;
    if (rx_valid) begin
      unique case (r_state)
        ST_RECEIVE: begin
          unique case (1'b1)
            w_is_end: begin
              w_count_nx = '0;
              if (r_count == 3'd3 && !r_bytes[0][7]) begin
                w_push = 1'b1;
              end else if (r_count == 3'd5 && r_bytes[0][7]) begin
                w_push = 1'b1;
              end else if (r_count != 3'd0) begin
                w_err = 1'b1;
              end
            end
            w_is_esc: begin
              w_state_nx = ST_ESCAPE;
            end
            default: begin
              if (r_count == 3'd5) begin
                w_state_nx = ST_DISCARD;
              end else begin
                w_store    = 1'b1;
                w_count_nx = r_count + 3'd1;
              end
            end
          endcase
        end
        ST_ESCAPE: begin
          unique case (1'b1)
            w_is_esc_end, w_is_esc_esc: begin
              w_store_byte = w_is_esc_end ? SLIP_END : SLIP_ESC;
              if (r_count == 3'd5) begin
                w_state_nx = ST_DISCARD;
              end else begin
                w_store    = 1'b1;
                w_count_nx = r_count + 3'd1;
                w_state_nx = ST_RECEIVE;
              end
            end
            w_is_end: begin
              w_err      = 1'b1;
              w_count_nx = '0;
              w_state_nx = ST_RECEIVE;
            end
            default: begin
              w_state_nx = ST_DISCARD;
            end
          endcase
        end
        ST_DISCARD: begin
          if (w_is_end) begin
            w_err      = 1'b1;
            w_count_nx = '0;
            w_state_nx = ST_RECEIVE;
          end
        end
        default: begin
          w_state_nx = ST_RECEIVE;
          w_count_nx = '0;
        end
      endcase
    end
  end

  // Reads carry zero data even if stale write bytes sit in slots 3-4.
  assign w_push_cmd = {r_bytes[0], r_bytes[1], r_bytes[2],
                       (r_count == 3'd5) ? {r_bytes[3], r_bytes[4]}
                                         : 16'h0000};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_RECEIVE;
      r_count     <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        r_bytes[i] <= '0;
      end
    end else begin
      r_state     <= w_state_nx;
      r_count     <= w_count_nx;
      r_frame_err <= w_err;
      r_overflow  <= w_push & w_full;
      for (int i = 0; i < 5; i++) begin
        if (w_store && r_count == 3'(i)) begin
          r_bytes[i] <= w_store_byte;
        end
      end
    end
  end

  cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (w_push),
    .i_wr_data(w_push_cmd),
    .i_rd_en  (cmd_read_en),
    .o_rd_data(cmd),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign cmd_ready = ~w_empty;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

endmodule

// File: doc/cmd_receiver.md
# cmd_receiver

Upstream stage of the monitor command path: decodes the SLIP-framed byte stream from the host byte interface into 40-bit monitor commands. Validates frame length against the write flag and queues complete commands in a show-ahead FIFO. The command controller pops the FIFO through `cmd`/`cmd_ready`/`cmd_read_en`. Malformed frames and overflows are dropped and reported as single-cycle error strobes.

## Interface
- `FIFO_DEPTH`, default 8: number of command entries; must be a power of two, minimum 2.
- `clk` input 1: system clock.
- `rst_n` input 1: reset. One clock; reset is synchronous and active-low.
- `rx_byte` input 8: received byte.
- `rx_valid` input 1: one-cycle strobe; `rx_byte` valid this cycle. No backpressure.
- `cmd` output 40: FIFO head, `{write_flag, addr_group[6:0], addr[15:0], data[15:0]}`. Reads carry data = 16'h0000.
- `cmd_ready` output 1: FIFO not empty.
- `cmd_read_en` input 1: pop the head at this clock edge. Ignored when empty.
- `frame_err` output 1: one-cycle pulse when a frame is discarded.
- `overflow` output 1: one-cycle pulse when a valid command is dropped because the FIFO is full.

## Operation
- SLIP constants: END = C0, ESC = DB, ESC_END = DC, ESC_ESC = DD.
- Frame payload bytes, in order: byte0 = `{write_flag, addr_group}`, then addr_hi, addr_lo, data_hi, data_lo.
  - A read frame is exactly 3 payload bytes.
  - A write frame is exactly 5 payload bytes.
- The FSM samples a byte only on `rx_valid`. States:
  - RECEIVE:
    - END: evaluate the frame, clear the byte count, stay in RECEIVE.
    - ESC: go to ESCAPE.
    - Any other byte: store it at index `count`, increment `count`.
    - If a stored byte would be the 6th, go to DISCARD instead.
  - ESCAPE:
    - DC: store C0. DD: store DB. Either way return to RECEIVE, with the same 6th-byte rule.
    - END: the frame is invalid. Pulse `frame_err`, clear the count, go to RECEIVE.
    - Any other byte: go to DISCARD.
  - DISCARD:
    - Ignore everything except END.
    - On END: pulse `frame_err`, clear the count, go to RECEIVE.
- Frame evaluation on END in RECEIVE:
  - `count` = 0: silent no-op. Back-to-back END bytes are idle padding.
  - `count` = 3 with byte0[7] = 0: push `{byte0, addr, 16'h0000}`.
  - `count` = 5 with byte0[7] = 1: push `{byte0, addr, data}`.
  - Any other count/flag combination: no push, pulse `frame_err`.
- Push when full: the command is dropped and `overflow` pulses. The FIFO is not modified.
  - Fullness is judged on the pre-pop occupancy, so a same-cycle pop does not rescue the push.
- Push and pop in the same cycle while not empty and not full: occupancy unchanged, head advances.
- Byte bits other than byte0[7] are not interpreted. The address group is not validated here.

## Timing
- Reset values:
  - `cmd` = 0, `cmd_ready` = 0, `frame_err` = 0, `overflow` = 0.
  - FSM = RECEIVE, count = 0, FIFO empty.
- Reset mid-frame discards the partial frame and all queued commands.
- Latency: END sampled in cycle N, FIFO written at the end of cycle N, `cmd_ready` = 1 and `cmd` valid in cycle N+1.
- `frame_err` and `overflow` are registered and high in cycle N+1 only.
- Pop: with `cmd_read_en` = 1 in cycle M, `cmd` shows the next entry in M+1. `cmd_ready` drops in M+1 if the FIFO becomes empty.
- The design sustains one `rx_valid` per cycle. A minimum 4-byte frame (3 payload + END) yields at most one command per 4 cycles.
- Read and write pointers are log2(`FIFO_DEPTH`) bits and wrap naturally. Occupancy is log2(`FIFO_DEPTH`)+1 bits.

## Structure
- SLIP byte constants go in `monitor_defs.v` as `SLIP_END`, `SLIP_ESC`, `SLIP_ESC_END` and `SLIP_ESC_ESC`, beside the existing address-group defines.
- Sub-module `cmd_fifo`: synchronous, show-ahead, 40-bit wide, parameterised depth. Exposes `full`/`empty`.
- The top level holds the SLIP FSM, the 5-byte assembly register, the count, and the strobes.

## Test plan
- Read frame: bytes 00 12 34 C0 -> `cmd` = 40'h0012340000, `cmd_ready` one cycle after the C0 byte.
- Write frame with escaping: 81 00 10 DB DC DB DD C0 -> `cmd` = 40'h810010C0DB, `frame_err` = 0.
- Bad length: 80 00 01 C0 (write, 3 bytes) and 00 00 01 02 03 04 C0 (6 bytes) -> no push, one `frame_err` pulse each. The following valid frame is accepted.
- Bad escape: 00 DB 55 00 01 C0 -> `frame_err` once, no push. ESC then END (00 DB C0) -> `frame_err`, next frame accepted.
- Overflow: `FIFO_DEPTH`+1 read frames with no pops -> `overflow` on the last, `FIFO_DEPTH` entries popped in order. Push on full with a same-cycle pop -> still dropped.
- Idle padding and reset: C0 C0 C0 -> no output, no errors. `rst_n` low mid-frame then 00 00 05 C0 -> only `cmd` = 40'h0000050000.
